sp_ram_arbiter: RTL and testbench



---
 rtl/sp_ram_arbiter_pkg.sv | 17 +
 rtl/sp_ram_arbiter_if.sv | 27 ++
 rtl/sp_ram_arbiter_rr_prio_sel.sv | 49 ++++
 rtl/sp_ram_arbiter.sv | 115 +++++++++++
 tb/tb_sp_ram_arbiter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sp_ram_arbiter_pkg.sv
// Shared constants and types for the single-port SRAM arbiter.
package sp_ram_arb_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int BE_WIDTH   = 4;

  typedef enum logic {
    ARB_ROUND_ROBIN = 1'b0,
    ARB_FIXED       = 1'b1
  } arb_mode_e;

  // Index width that stays legal for a single-master build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sp_ram_arbiter_if.sv
// Per-master req/gnt/rvalid bus between the requesters and the arbiter.
interface sp_ram_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 13
);
  import sp_ram_arb_pkg::*;

  logic [NUM_MASTERS-1:0]                 m_req_i;
  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] m_addr_i;
  logic [NUM_MASTERS-1:0]                 m_we_i;
  logic [NUM_MASTERS-1:0][BE_WIDTH-1:0]   m_be_i;
  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_wdata_i;
  logic [NUM_MASTERS-1:0]                 m_gnt_o;
  logic [NUM_MASTERS-1:0]                 m_rvalid_o;
  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_rdata_o;

  modport slave (
    input  m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i,
    output m_gnt_o, m_rvalid_o, m_rdata_o
  );

  modport master (
    output m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i,
    input  m_gnt_o, m_rvalid_o, m_rdata_o
  );

endinterface

// File: rtl/sp_ram_arbiter_rr_prio_sel.sv
// Combinational N-way picker: first requester scanning from i_ptr (rotating),
// or from index 0 when i_fixed is set.
module rr_prio_sel
  import sp_ram_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0]             i_req,
  input  logic [idx_width(NUM_MASTERS)-1:0]  i_ptr,
  input  logic                               i_fixed,
  output logic [NUM_MASTERS-1:0]             o_gnt,
  output logic [idx_width(NUM_MASTERS)-1:0]  o_idx,
  output logic                               o_valid
);

  localparam int IDX_W = idx_width(NUM_MASTERS);

  logic [IDX_W-1:0] w_base;
  logic             w_found;
  logic [IDX_W-1:0] w_idx;

  function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] base, input int off);
    int unsigned s;
    s = (32'(base) + 32'(off)) % 32'(NUM_MASTERS);
    return s[IDX_W-1:0];
  endfunction

  assign w_base = i_fixed ? '0 : i_ptr;

  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!w_found && i_req[rot_idx(w_base, i)]) begin
        w_found = 1'b1;
        w_idx   = rot_idx(w_base, i);
      end
    end
  end

  always_comb begin
    o_gnt        = '0;
    o_gnt[w_idx] = w_found;
  end

  assign o_idx   = w_idx;
  assign o_valid = w_found;

endmodule

// File: rtl/sp_ram_arbiter.sv
// Shares one single-port SRAM (1-cycle read latency) between NUM_MASTERS
// requesters; grants one access per cycle and routes the response back.
module sp_ram_arbiter
  import sp_ram_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 13,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  sp_ram_arbiter_if.slave                       bus,
  output logic                                  mem_en_o,
  output logic [ADDR_WIDTH-1:0]                 mem_addr_o,
  output logic                                  mem_we_o,
  output logic [BE_WIDTH-1:0]                   mem_be_o,
  output logic [DATA_WIDTH-1:0]                 mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]                 mem_rdata_i,
  input  logic                                  fixed_prio_i,
  input  logic                                  stall_clr_i,
  output logic [NUM_MASTERS-1:0][CNT_WIDTH-1:0] stall_cnt_o
);

  localparam int IDX_W = idx_width(NUM_MASTERS);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [BE_WIDTH-1:0]   be;
    logic [DATA_WIDTH-1:0] wdata;
  } mem_req_t;

  arb_mode_e                            w_mode;
  logic [NUM_MASTERS-1:0]               w_gnt;
  logic [IDX_W-1:0]                     w_win;
  logic                                 w_any;
  logic [IDX_W-1:0]                     w_next_ptr;
  mem_req_t                             w_sel;
  logic [NUM_MASTERS-1:0]               w_rvalid;

  logic [IDX_W-1:0]                     r_rr_ptr;
  logic [IDX_W-1:0]                     r_owner;
  logic                                 r_rvalid;
  logic [NUM_MASTERS-1:0][CNT_WIDTH-1:0] r_stall_cnt;

  assign w_mode = fixed_prio_i ? ARB_FIXED : ARB_ROUND_ROBIN;

  rr_prio_sel #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_sel (
    .i_req   (bus.m_req_i),
    .i_ptr   (r_rr_ptr),
    .i_fixed (w_mode == ARB_FIXED),
    .o_gnt   (w_gnt),
    .o_idx   (w_win),
    .o_valid (w_any)
  );

  // With no request the picker reports index 0, so the mux parks on master 0.
  always_comb begin
    w_sel.addr  = bus.m_addr_i[w_win];
    w_sel.we    = bus.m_we_i[w_win];
    w_sel.be    = bus.m_be_i[w_win];
    w_sel.wdata = bus.m_wdata_i[w_win];
  end

  assign mem_en_o    = |bus.m_req_i;
  assign mem_addr_o  = w_sel.addr;
  assign mem_we_o    = w_sel.we;
  assign mem_be_o    = w_sel.be;
  assign mem_wdata_o = w_sel.wdata;
  assign bus.m_gnt_o = w_gnt;

  assign w_next_ptr = (w_win == IDX_W'(NUM_MASTERS - 1)) ? '0 : w_win + 1'b1;

  // Grant edge: pointer advance and response tracking.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr <= '0;
      r_rvalid <= 1'b0;
      r_owner  <= '0;
    end else begin
      r_rvalid <= w_any;
      r_owner  <= w_win;
      if (w_any && (w_mode == ARB_ROUND_ROBIN)) begin
        r_rr_ptr <= w_next_ptr;
      end
    end
  end

  // Saturating contention counters; clear beats increment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        if (stall_clr_i) begin
          r_stall_cnt[k] <= '0;
        end else if (bus.m_req_i[k] && !w_gnt[k] && (r_stall_cnt[k] != '1)) begin
          r_stall_cnt[k] <= r_stall_cnt[k] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_rvalid          = '0;
    w_rvalid[r_owner] = r_rvalid;
  end

  assign bus.m_rvalid_o = w_rvalid;
  assign bus.m_rdata_o  = {NUM_MASTERS{mem_rdata_i}};
  assign stall_cnt_o    = r_stall_cnt;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed bench for sp_ram_arbiter with a behavioural SRAM and a response scoreboard.
module tb_sp_ram_arbiter;
  import sp_ram_arb_pkg::*;

  localparam int N    = 2;
  localparam int AW   = 13;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   fixed_prio;
  logic                   stall_clr;
  logic                   mem_en;
  logic [AW-1:0]          mem_addr;
  logic                   mem_we;
  logic [3:0]             mem_be;
  logic [31:0]            mem_wdata;
  logic [31:0]            mem_rdata;
  logic [N-1:0][CW-1:0]   stall_cnt;

  always #5 clk = ~clk;

  sp_ram_arbiter_if #(.NUM_MASTERS(N), .ADDR_WIDTH(AW)) bus ();

  sp_ram_arbiter #(
    .NUM_MASTERS (N),
    .ADDR_WIDTH  (AW),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bus          (bus),
    .mem_en_o     (mem_en),
    .mem_addr_o   (mem_addr),
    .mem_we_o     (mem_we),
    .mem_be_o     (mem_be),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata),
    .fixed_prio_i (fixed_prio),
    .stall_clr_i  (stall_clr),
    .stall_cnt_o  (stall_cnt)
  );

  // Behavioural single-port SRAM with one-cycle read latency.
  logic [31:0] sram [0:(1<<AW)-1];
  always_ff @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  typedef struct {
    int          master;
    bit          we;
    logic [31:0] data;
    int          due;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] ref_mem [0:(1<<AW)-1];
  int          model_ptr;
  int          model_cnt [N];
  int          cyc;
  int          n_pass;
  int          n_fail;
  int          n_total;
  logic [N-1:0] last_gnt;
  logic [N-1:0] last_rv;
  logic [31:0]  last_rdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_win(input logic [N-1:0] req, input int ptr, input bit fx);
    for (int i = 0; i < N; i++) begin
      int k;
      k = fx ? i : (ptr + i) % N;
      if (req[k]) return k;
    end
    return -1;
  endfunction

  task automatic drive(input int m, input bit req, input bit we, input logic [AW-1:0] addr,
                       input logic [3:0] be, input logic [31:0] wd);
    bus.m_req_i[m]   = req;
    bus.m_we_i[m]    = we;
    bus.m_addr_i[m]  = addr;
    bus.m_be_i[m]    = be;
    bus.m_wdata_i[m] = wd;
  endtask

  task automatic idle_all();
    for (int m = 0; m < N; m++) drive(m, 1'b0, 1'b0, '0, 4'h0, 32'h0);
  endtask

  // One clock: compare mid-cycle, update the model, then step to posedge+1.
  task automatic cycle();
    int           w;
    int           sel;
    logic [N-1:0] exp_gnt;
    logic [N-1:0] exp_rv;
    logic [31:0]  wd;
    logic [AW-1:0] a;
    sb_t          e;
    #3;
    if (rst) begin
      model_ptr = 0;
      for (int k = 0; k < N; k++) model_cnt[k] = 0;
    end
    last_gnt = bus.m_gnt_o;
    last_rv  = bus.m_rvalid_o;
    exp_rv   = '0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      exp_rv[e.master] = 1'b1;
      check("rvalid", 64'(bus.m_rvalid_o), 64'(exp_rv));
      if (!e.we) begin
        last_rdata = bus.m_rdata_o[e.master];
        check("rdata", 64'(last_rdata), 64'(e.data));
      end
    end else begin
      check("rvalid_idle", 64'(bus.m_rvalid_o), 64'(exp_rv));
    end
    w = model_win(bus.m_req_i, model_ptr, fixed_prio);
    exp_gnt = '0;
    if (w >= 0) exp_gnt[w] = 1'b1;
    check("gnt", 64'(bus.m_gnt_o), 64'(exp_gnt));
    check("mem_en", 64'(mem_en), 64'(|bus.m_req_i));
    sel = (w >= 0) ? w : 0;
    check("mem_addr", 64'(mem_addr), 64'(bus.m_addr_i[sel]));
    check("mem_we", 64'(mem_we), 64'(bus.m_we_i[sel]));
    check("mem_be", 64'(mem_be), 64'(bus.m_be_i[sel]));
    check("mem_wdata", 64'(mem_wdata), 64'(bus.m_wdata_i[sel]));
    for (int k = 0; k < N; k++) check("stall_cnt", 64'(stall_cnt[k]), 64'(model_cnt[k]));
    if (!rst) begin
      if (w >= 0) begin
        a = bus.m_addr_i[w];
        if (bus.m_we_i[w]) begin
          wd = ref_mem[a];
          for (int b = 0; b < 4; b++) begin
            if (bus.m_be_i[w][b]) wd[b*8 +: 8] = bus.m_wdata_i[w][b*8 +: 8];
          end
          ref_mem[a] = wd;
          sb.push_back('{w, 1'b1, 32'h0, cyc + 1});
        end else begin
          sb.push_back('{w, 1'b0, ref_mem[a], cyc + 1});
        end
        if (!fixed_prio) model_ptr = (w + 1) % N;
      end
      for (int k = 0; k < N; k++) begin
        if (stall_clr) model_cnt[k] = 0;
        else if (bus.m_req_i[k] && !exp_gnt[k] && model_cnt[k] < CMAX) model_cnt[k]++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0; cyc = 0;
    model_ptr = 0;
    for (int k = 0; k < N; k++) model_cnt[k] = 0;
    last_rdata = '0;
    rst = 1'b1; fixed_prio = 1'b0; stall_clr = 1'b0;
    idle_all();
    #1;
    check("reset_rvalid", 64'(bus.m_rvalid_o), 64'h0);
    check("reset_stall", 64'(stall_cnt), 64'h0);
    cycle();
    cycle();
    rst = 1'b0;

    // Single master write then read.
    drive(0, 1'b1, 1'b1, 13'h0010, 4'hF, 32'hDEADBEEF);
    cycle();
    check("t1_wr_gnt", 64'(last_gnt), 64'h1);
    drive(0, 1'b1, 1'b0, 13'h0010, 4'hF, 32'h0);
    cycle();
    check("t1_rd_gnt", 64'(last_gnt), 64'h1);
    check("t1_wr_ack", 64'(last_rv), 64'h1);
    idle_all();
    cycle();
    check("t1_rd_rv", 64'(last_rv), 64'h1);
    check("t1_rdata", 64'(last_rdata), 64'hDEADBEEF);

    // Round-robin contention, starting from rr_ptr = 0 with cleared counters.
    drive(1, 1'b1, 1'b1, 13'h0020, 4'hF, 32'h0000_5555);
    stall_clr = 1'b1;
    cycle();
    stall_clr = 1'b0;
    drive(0, 1'b1, 1'b0, 13'h0010, 4'hF, 32'h0);
    drive(1, 1'b1, 1'b1, 13'h0020, 4'hF, 32'h1234_5678);
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("rr_gnt", 64'(last_gnt), (i % 2 == 0) ? 64'h1 : 64'h2);
    end
    idle_all();
    cycle();
    check("rr_stall0", 64'(stall_cnt[0]), 64'd3);
    check("rr_stall1", 64'(stall_cnt[1]), 64'd3);

    // Fixed priority, then switch back to round-robin with rr_ptr = 1.
    drive(0, 1'b1, 1'b0, 13'h0010, 4'hF, 32'h0);
    stall_clr = 1'b1;
    cycle();
    stall_clr  = 1'b0;
    fixed_prio = 1'b1;
    drive(1, 1'b1, 1'b1, 13'h0020, 4'hF, 32'h0BAD_F00D);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("fp_gnt", 64'(last_gnt), 64'h1);
    end
    fixed_prio = 1'b0;
    check("fp_stall1", 64'(stall_cnt[1]), 64'd4);
    cycle();
    check("fp_switch_gnt", 64'(last_gnt), 64'h2);

    // Starve master 1 until saturation, then clear while still stalled.
    fixed_prio = 1'b1;
    stall_clr  = 1'b1;
    cycle();
    stall_clr = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
    check("sat_stall1", 64'(stall_cnt[1]), 64'(CMAX));
    stall_clr = 1'b1;
    cycle();
    check("clr_stall1", 64'(stall_cnt[1]), 64'd0);
    stall_clr = 1'b0;
    cycle();
    check("clr_then_inc", 64'(stall_cnt[1]), 64'd1);

    // Reset in the cycle after a grant to master 1.
    fixed_prio = 1'b0;
    idle_all();
    drive(1, 1'b1, 1'b1, 13'h0030, 4'hF, 32'hCAFE_0001);
    cycle();
    check("rst_pre_gnt", 64'(last_gnt), 64'h2);
    idle_all();
    rst = 1'b1;
    sb.delete();
    cycle();
    check("rst_no_rvalid", 64'(last_rv), 64'h0);
    cycle();
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 13'h0010, 4'hF, 32'h0);
    drive(1, 1'b1, 1'b1, 13'h0030, 4'hF, 32'hCAFE_0002);
    cycle();
    check("rst_post_gnt", 64'(last_gnt), 64'h1);
    idle_all();
    cycle();

    // Partial byte-enable write.
    drive(0, 1'b1, 1'b1, 13'h0040, 4'hF, 32'h1122_3344);
    cycle();
    drive(0, 1'b1, 1'b1, 13'h0040, 4'h3, 32'hAABB_CCDD);
    cycle();
    drive(0, 1'b1, 1'b0, 13'h0040, 4'hF, 32'h0);
    cycle();
    idle_all();
    cycle();
    check("be_rdata", 64'(last_rdata), 64'h1122_CCDD);
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
